// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status constants, message record and data-count lookup.
package midi_pkg;

  localparam logic [7:0] MIDI_NOTE_OFF  = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON   = 8'h90;
  localparam logic [7:0] MIDI_POLY_AT   = 8'hA0;
  localparam logic [7:0] MIDI_CC        = 8'hB0;
  localparam logic [7:0] MIDI_PROG_CHG  = 8'hC0;
  localparam logic [7:0] MIDI_CHAN_AT   = 8'hD0;
  localparam logic [7:0] MIDI_PITCH     = 8'hE0;
  localparam logic [7:0] MIDI_SYSEX     = 8'hF0;
  localparam logic [7:0] MIDI_MTC_QF    = 8'hF1;
  localparam logic [7:0] MIDI_SONG_POS  = 8'hF2;
  localparam logic [7:0] MIDI_SONG_SEL  = 8'hF3;
  localparam logic [7:0] MIDI_TUNE_REQ  = 8'hF6;
  localparam logic [7:0] MIDI_EOX       = 8'hF7;
  localparam logic [7:0] MIDI_RT_CLOCK  = 8'hF8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] data1;
    logic [6:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  function automatic logic [1:0] midi_data_count(input logic [7:0] status);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: cnt = 2'd2;
      4'hC, 4'hD:                   cnt = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: cnt = 2'd1;
          4'h2:       cnt = 2'd2;
          default:    cnt = 2'd0;
        endcase
      end
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

  function automatic midi_msg_t midi_msg(input logic [7:0] status, input logic [6:0] data1,
                                         input logic [6:0] data2, input logic [1:0] len);
    midi_msg_t m;
    m.status = status;
    m.data1  = data1;
    m.data2  = data2;
    m.len    = len;
    return m;
  endfunction

endpackage

// File: rtl/midi_rx_uart.sv
// MIDI line synchronizer and byte receiver (start/8 data/stop, LSB first).
module midi_rx_uart
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 180000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       midi_rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       ferr_o
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            prev_r;
  rx_state_t       state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;

  // Synchronizer, bit timing and byte framing; sync flops reset low so a low line never arms.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      prev_r     <= 1'b0;
      state_r    <= RX_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      byte_o     <= 8'd0;
      byte_vld_o <= 1'b0;
      ferr_o     <= 1'b0;
    end else begin
      sync1_r    <= midi_rx_i;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      byte_vld_o <= 1'b0;
      ferr_o     <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (prev_r && !sync2_r) begin
            state_r <= RX_START;
            cnt_r   <= '0;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (sync2_r) begin
              byte_o     <= shift_r;
              byte_vld_o <= 1'b1;
            end else begin
              ferr_o <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI receive parser: running status, system common, sysex drop and realtime handling.
// Optional feature macro MIDI_RX_REALTIME_EN: emit 0xF8-0xFF realtime bytes as len-0 messages.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 180000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       midi_rx_i,
  output logic [7:0] status_o,
  output logic [6:0] data1_o,
  output logic [6:0] data2_o,
  output logic [1:0] len_o,
  output logic       msg_vld_o,
  output logic       err_o
);

  logic [7:0] rx_byte_s;
  logic       rx_vld_s;
  logic       rx_ferr_s;

  logic [7:0] byte_r;
  logic       byte_vld_r;
  logic [7:0] run_status_r;
  logic       run_vld_r;
  logic       sys_r;
  logic [1:0] exp_r;
  logic       idx_r;
  logic [6:0] d1_r;
  midi_msg_t  msg_r;

  midi_rx_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .midi_rx_i  (midi_rx_i),
    .byte_o     (rx_byte_s),
    .byte_vld_o (rx_vld_s),
    .ferr_o     (rx_ferr_s)
  );

  assign status_o = msg_r.status;
  assign data1_o  = msg_r.data1;
  assign data2_o  = msg_r.data2;
  assign len_o    = msg_r.len;

  // Byte staging register plus message assembly; a framing error drops the partial message only.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_r       <= 8'd0;
      byte_vld_r   <= 1'b0;
      run_status_r <= 8'd0;
      run_vld_r    <= 1'b0;
      sys_r        <= 1'b0;
      exp_r        <= 2'd0;
      idx_r        <= 1'b0;
      d1_r         <= 7'd0;
      msg_r        <= '0;
      msg_vld_o    <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      byte_r     <= rx_byte_s;
      byte_vld_r <= rx_vld_s;
      err_o      <= rx_ferr_s;
      msg_vld_o  <= 1'b0;
      if (rx_ferr_s) begin
        idx_r <= 1'b0;
      end else if (byte_vld_r) begin
        if (!byte_r[7]) begin
          if (run_vld_r) begin
            if (!idx_r && exp_r == 2'd2) begin
              d1_r  <= byte_r[6:0];
              idx_r <= 1'b1;
            end else begin
              msg_vld_o <= 1'b1;
              msg_r     <= idx_r ? midi_msg(run_status_r, d1_r, byte_r[6:0], 2'd2)
                                 : midi_msg(run_status_r, byte_r[6:0], 7'd0, 2'd1);
              idx_r     <= 1'b0;
              if (sys_r) begin
                run_vld_r <= 1'b0;
              end
            end
          end
        end else if (byte_r >= MIDI_RT_CLOCK) begin
`ifdef MIDI_RX_REALTIME_EN
          msg_vld_o <= 1'b1;
          msg_r     <= midi_msg(byte_r, 7'd0, 7'd0, 2'd0);
`endif
        end else if (byte_r < MIDI_SYSEX) begin
          run_status_r <= byte_r;
          run_vld_r    <= 1'b1;
          sys_r        <= 1'b0;
          exp_r        <= midi_data_count(byte_r);
          idx_r        <= 1'b0;
        end else begin
          case (byte_r)
            MIDI_MTC_QF, MIDI_SONG_POS, MIDI_SONG_SEL: begin
              run_status_r <= byte_r;
              run_vld_r    <= 1'b1;
              sys_r        <= 1'b1;
              exp_r        <= midi_data_count(byte_r);
              idx_r        <= 1'b0;
            end
            MIDI_TUNE_REQ: begin
              msg_vld_o <= 1'b1;
              msg_r     <= midi_msg(byte_r, 7'd0, 7'd0, 2'd0);
              run_vld_r <= 1'b0;
              idx_r     <= 1'b0;
            end
            default: begin
              run_vld_r <= 1'b0;
              idx_r     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser at CLK_HZ=500000 (16 clocks per MIDI bit).
`timescale 1ns/1ps
module tb_midi_rx_parser;

  localparam int  CLK_HZ = 500000;
  localparam int  BAUD   = 31250;
  localparam int  DIV    = 16;
  localparam int  PERIOD = 2000;
  localparam int  LAT    = 2 + DIV / 2 + 9 * DIV + 2;

  typedef struct {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       midi_rx = 1'b0;
  logic [7:0] status;
  logic [6:0] data1;
  logic [6:0] data2;
  logic [1:0] len;
  logic       msg_vld;
  logic       err;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   err_pulses = 0;
  int   lat;
  time  last_fall = 0;

  midi_rx_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .midi_rx_i (midi_rx),
    .status_o  (status),
    .data1_o   (data1),
    .data2_o   (data2),
    .len_o     (len),
    .msg_vld_o (msg_vld),
    .err_o     (err)
  );

  always #(PERIOD / 2) clk = ~clk;

  task automatic push_exp(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                          input logic [1:0] l);
    exp_t e;
    e.st = st; e.d1 = d1; e.d2 = d2; e.len = l;
    exp_q.push_back(e);
  endtask

  // Frame bits: start, 8 data LSB first, stop. rst_bit >= 0 asserts reset mid-way through that bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      midi_rx = frame[i];
      if (i == 0) last_fall = $time;
      if (i == rst_bit) begin
        repeat (DIV / 2) @(posedge clk);
        #1 rstn = 1'b0;
        repeat (DIV / 2) @(posedge clk);
        #1;
      end else begin
        repeat (DIV) @(posedge clk);
        #1;
      end
    end
    midi_rx = 1'b1;
  endtask

  task automatic sb(input logic [7:0] b);
    send_frame(b, 1'b1, -1);
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * DIV) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (status !== 8'd0 || data1 !== 7'd0 || data2 !== 7'd0 || len !== 2'd0 ||
        msg_vld !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got status=%h d1=%h d2=%h len=%0d vld=%b err=%b, expected all zero",
               name, status, data1, data2, len, msg_vld, err);
    end
  endtask

  // Monitor: pop and compare every presented message, count error pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (err === 1'b1) err_pulses++;
      if (msg_vld === 1'b1) begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL vld_err_overlap: got err=%b with msg_vld, expected 0", err);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_msg: got status=%h d1=%h d2=%h len=%0d, expected none",
                   status, data1, data2, len);
        end else begin
          mon_e = exp_q.pop_front();
          if (status !== mon_e.st || data1 !== mon_e.d1 || data2 !== mon_e.d2 || len !== mon_e.len) begin
            errors++;
            $display("FAIL msg_fields: got %h/%h/%h len=%0d, expected %h/%h/%h len=%0d",
                     status, data1, data2, len, mon_e.st, mon_e.d1, mon_e.d2, mon_e.len);
          end
          checks++;
          lat = int'(($time - last_fall) / PERIOD);
          if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL msg_latency: got %0d cycles, expected %0d +/-1", lat, LAT);
          end
        end
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    midi_rx = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(12);
    midi_rx = 1'b1;
    idle(4);

    push_exp(8'h90, 7'h3C, 7'h64, 2'd2);
    sb(8'h90); sb(8'h3C); sb(8'h64);
    idle(4);

    push_exp(8'h90, 7'h3C, 7'h64, 2'd2);
    push_exp(8'h90, 7'h3E, 7'h00, 2'd2);
    sb(8'h90); sb(8'h3C); sb(8'h64); sb(8'h3E); sb(8'h00);
    idle(4);

`ifdef MIDI_RX_REALTIME_EN
    push_exp(8'hF8, 7'h00, 7'h00, 2'd0);
`endif
    push_exp(8'h90, 7'h3C, 7'h64, 2'd2);
    sb(8'h90); sb(8'h3C); sb(8'hF8); sb(8'h64);
    idle(4);

    push_exp(8'hC0, 7'h05, 7'h00, 2'd1);
    push_exp(8'hC0, 7'h06, 7'h00, 2'd1);
    sb(8'hC0); sb(8'h05); sb(8'h06);
    idle(4);
    sb(8'hF0); sb(8'h7E); sb(8'h01); sb(8'hF7); sb(8'h3C);
    idle(4);

    send_frame(8'h90, 1'b0, -1);
    idle(2);
    push_exp(8'h90, 7'h3C, 7'h64, 2'd2);
    sb(8'h90); sb(8'h3C); sb(8'h64);
    idle(4);
    midi_rx = 1'b0;
    #30 midi_rx = 1'b1;
    idle(20);

    sb(8'h90);
    send_frame(8'h3C, 1'b1, 5);
    @(negedge clk);
    check_zero("reset_mid_byte");
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(4);
    sb(8'h3C); sb(8'h64);
    idle(4);
    push_exp(8'h80, 7'h3C, 7'h00, 2'd2);
    sb(8'h80); sb(8'h3C); sb(8'h00);
    idle(6);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_msgs: got %0d messages still pending, expected 0", exp_q.size());
    end
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL err_pulses: got %0d, expected 1", err_pulses);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Receives the 31.25 kbaud MIDI serial stream on the core clock and assembles complete MIDI messages. It synchronizes and samples the line, recovers bytes, and applies running status and realtime interleaving rules. Each complete channel or system-common message is presented as one registered, single-cycle-valid record to the core's register space. It is the receive counterpart of the existing MIDI transmit path and sits beside it under the theremin top level.

## Interface

Clock is `clk_i`. Reset is `rstn_i`: asynchronous, active-low.

Parameters:
- `CLK_HZ`, 180000000: core clock frequency in Hz.
- `BAUD`, 31250: line bit rate.

Ports:
- `clk_i`, in, 1: core clock.
- `rstn_i`, in, 1: async reset, active low.
- `midi_rx_i`, in, 1: raw serial line, idle high, asynchronous to `clk_i`.
- `status_o`, out, 8: status byte of the message.
- `data1_o`, out, 7: first data byte.
- `data2_o`, out, 7: second data byte.
- `len_o`, out, 2: number of data bytes, 0..2.
- `msg_vld_o`, out, 1: one-cycle pulse; the message fields are valid in that cycle and held until the next message.
- `err_o`, out, 1: one-cycle pulse on a framing error.

## Operation

- **Line input and bit timing**
  - `midi_rx_i` passes through a 2-flop synchronizer.
  - `DIV = round(CLK_HZ/BAUD)`. The bit counter is `$clog2(DIV)` bits wide.
- **Byte receiver states: IDLE, START, DATA, STOP**
  - IDLE: leaves on a synchronized falling edge (previous sample 1, current sample 0). A line held low never re-arms the receiver.
  - START: samples at `DIV/2` (floor). If the sample is 1 it is a glitch: return to IDLE with no error.
  - DATA: 8 samples spaced `DIV` apart, LSB first.
  - STOP: samples one `DIV` later.
    - Sample 1: byte valid.
    - Sample 0: `err_o` pulse, byte discarded. Any partial message is discarded (data index cleared); running status is kept.
  - Return to IDLE in both cases.
- **Parser** (acts on each valid byte)
  - 0x80–0xEF: set running status and clear the data index. Expected data count is 1 for 0xC0–0xDF, otherwise 2.
  - 0xF1, 0xF3: system common, expects 1 data byte. 0xF2 expects 2.
  - 0xF6: emit immediately with `len_o`=0.
  - 0xF0, 0xF4, 0xF5, 0xF7: clear running status. Following data bytes are discarded, so sysex payload is dropped.
  - System-common messages clear running status after they emit.
  - 0xF8–0xFF: realtime (see Configuration). Never alters running status or the data index.
  - Data byte 0x00–0x7F:
    - No running status: discarded.
    - Otherwise stored in `data1_o`/`data2_o` by index.
    - When the expected count is reached: emit, reset the index, and keep running status for channel messages.
- **Output rules**
  - Unused data fields are driven 0 when `len_o` < 2.
  - Reset values: every output 0, running status cleared, receiver in IDLE.

## Timing

- `msg_vld_o` rises 2 cycles after the clock edge on which the final stop-bit sample is taken: 1 cycle to register the byte, 1 for the parser.
- From the `midi_rx_i` falling edge of the final byte's start bit to `msg_vld_o`: 2 + floor(`DIV/2`) + 9·`DIV` + 2 cycles, ±1 cycle of synchronizer phase.
- `err_o` rises 1 cycle after the failing stop sample.
- `msg_vld_o` and `err_o` are never high in the same cycle.
- Back-to-back bytes with no idle time are supported. The falling edge of the next start bit may arrive at the cycle of the stop sample.
- Reset asserted mid-byte or mid-message:
  - All state is abandoned immediately.
  - After deassertion the receiver starts in IDLE.
  - A line that is low at deassertion is ignored until it goes high and falls again.

## Configuration

- `MIDI_RX_REALTIME_EN` defined: each 0xF8–0xFF byte emits `msg_vld_o` with `status_o`=byte and `len_o`=0, immediately and even in the middle of a partially assembled message. The partial message is preserved.
- Undefined: realtime bytes are silently dropped. No other behaviour changes.

## Structure

- Shared package `midi_pkg`:
  - status constants (`MIDI_NOTE_ON`, `MIDI_SYSEX`, `MIDI_RT_CLOCK`, …)
  - message record typedef `midi_msg_t` (status, data1, data2, len)
  - a function returning the expected data count for a status byte
- Sub-module `midi_rx_uart`: synchronizer plus the byte-receiver state machine.
  - Outputs `byte_o[7:0]`, `byte_vld_o`, `ferr_o`.
  - The parser lives in the top module.

## Test plan

Use `CLK_HZ`=500000, so `DIV`=16.

1. Bytes 90 3C 64 → one `msg_vld_o`: `status_o`=0x90, `data1_o`=0x3C, `data2_o`=0x64, `len_o`=2, at the latency stated in Timing.
2. Bytes 90 3C 64 3E 00 → two messages; the second is 0x90/0x3E/0x00 via running status.
3. Bytes 90 3C F8 64:
   - with the macro: F8 message (`len_o`=0), then 0x90/0x3C/0x64
   - without the macro: only the note message
4. Bytes C0 05 06 → two messages, 0xC0/0x05 and 0xC0/0x06, both `len_o`=1. Then F0 7E 01 F7 3C → no messages.
5. Byte 90 sent with stop bit 0 → `err_o` pulse, no message. Then 90 3C 64 → correct message. A 30 ns low glitch on the idle line → nothing.
6. `rstn_i` asserted during data bit 4 of 3C after 90 → all outputs 0. After release, 3C 64 → no message (running status was cleared). Then 80 3C 00 → 0x80/0x3C/0x00.
